// File: rtl/y86_dmem_responder.sv
// Y86 data-memory responder: byte-addressed little-endian quad reads/writes behind valid/ready
// handshakes with a fixed LATENCY. Optional access counters are enabled with macro DMEM_STATS_EN.
module y86_dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_errs
`endif
);

    localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Full 64-bit compare so addresses near 2^64 never wrap into range.
    function automatic logic addr_err(input logic [63:0] addr);
        return (addr > ADDR_MAX);
    endfunction

    logic [7:0]    mem_r [MEM_BYTES];

    state_t        state_r, state_s;
    logic [3:0]    cnt_r, cnt_s;
    logic          wr_r, wr_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [63:0]   wdata_r, wdata_s;
    logic          err_r, err_s;
    logic          req_ready_r, req_ready_s;
    logic          rsp_valid_r, rsp_valid_s;
    logic [63:0]   rsp_rdata_r, rsp_rdata_s;
    logic          rsp_err_r, rsp_err_s;

    logic          access_s;
    logic          acc_wr_s;
    logic [AW-1:0] acc_addr_s;
    logic [63:0]   acc_wdata_s;
    logic          acc_err_s;
    logic          mem_we_s;
    logic [63:0]   rd_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Access operands: live request for a zero-latency accept, latched copy otherwise.
    always_comb begin
        access_s    = 1'b0;
        acc_wr_s    = wr_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_err_s   = err_r;
        if (state_r == IDLE) begin
            acc_wr_s    = req_write;
            acc_addr_s  = req_addr[AW-1:0];
            acc_wdata_s = req_wdata;
            acc_err_s   = addr_err(req_addr);
            access_s    = ZERO_LAT && req_valid && req_ready_r;
        end else begin
            access_s    = (state_r == WAIT) && (cnt_r == 4'd0);
        end
        mem_we_s = access_s && acc_wr_s && !acc_err_s;
    end

    // Little-endian gather of the eight bytes at the access address.
    always_comb begin
        rd_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rd_s[8*i +: 8] = mem_r[acc_addr_s + AW'(i)];
        end
    end

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        wr_s        = wr_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        err_s       = err_r;
        req_ready_s = req_ready_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid && req_ready_r) begin
                    wr_s        = req_write;
                    addr_s      = req_addr[AW-1:0];
                    wdata_s     = req_wdata;
                    err_s       = addr_err(req_addr);
                    req_ready_s = 1'b0;
                    if (ZERO_LAT) begin
                        state_s = RESP;
                    end else begin
                        cnt_s   = CNT_INIT;
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                    rsp_rdata_s = 64'd0;
                    rsp_err_s   = 1'b0;
                    req_ready_s = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s     = IDLE;
                req_ready_s = 1'b0;
                rsp_valid_s = 1'b0;
                rsp_rdata_s = 64'd0;
                rsp_err_s   = 1'b0;
            end
        endcase
        // Response fields are captured on the same edge that performs the access.
        if (access_s) begin
            rsp_valid_s = 1'b1;
            rsp_err_s   = acc_err_s;
            rsp_rdata_s = (acc_wr_s || acc_err_s) ? 64'd0 : rd_s;
        end else begin
            rsp_valid_s = rsp_valid_s;
        end
    end

    // FSM state, latched request and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            wr_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 64'd0;
            err_r       <= 1'b0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            wr_r        <= wr_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            err_r       <= err_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    // Byte-lane store on the access edge; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[acc_addr_s + AW'(i)] <= acc_wdata_s[8*i +: 8];
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] stat_reads_r, stat_writes_r, stat_errs_r;

    assign stat_reads  = stat_reads_r;
    assign stat_writes = stat_writes_r;
    assign stat_errs   = stat_errs_r;

    // Per-handshake transaction counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads_r  <= 32'd0;
            stat_writes_r <= 32'd0;
            stat_errs_r   <= 32'd0;
        end else if ((state_r == RESP) && rsp_ready) begin
            if (wr_r) begin
                stat_writes_r <= stat_writes_r + 32'd1;
            end else begin
                stat_reads_r  <= stat_reads_r + 32'd1;
            end
            if (rsp_err_r) begin
                stat_errs_r <= stat_errs_r + 32'd1;
            end else begin
                stat_errs_r <= stat_errs_r;
            end
        end else begin
            stat_reads_r  <= stat_reads_r;
            stat_writes_r <= stat_writes_r;
            stat_errs_r   <= stat_errs_r;
        end
    end
`endif

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Directed bench for y86_dmem_responder: a LATENCY=2 instance driven from a vector table plus
// hand-written backpressure/reset sequences, and a LATENCY=0 instance for the short-latency path.
module tb_y86_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_write, rsp_ready;
    logic [63:0] req_addr, req_wdata;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [63:0] a_rsp_rdata;
    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_err;
    logic [63:0] z_rsp_rdata;
    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [63:0] rsp_rdata_m;

`ifdef DMEM_STATS_EN
    logic [31:0] a_stat_reads, a_stat_writes, a_stat_errs;
    logic [31:0] z_stat_reads, z_stat_writes, z_stat_errs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~sel;
    assign z_req_valid = req_valid & sel;
    assign req_ready_m = sel ? z_req_ready : a_req_ready;
    assign rsp_valid_m = sel ? z_rsp_valid : a_rsp_valid;
    assign rsp_err_m   = sel ? z_rsp_err   : a_rsp_err;
    assign rsp_rdata_m = sel ? z_rsp_rdata : a_rsp_rdata;

    y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
`ifdef DMEM_STATS_EN
        , .stat_reads(a_stat_reads), .stat_writes(a_stat_writes), .stat_errs(a_stat_errs)
`endif
    );

    y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_STATS_EN
        , .stat_reads(z_stat_reads), .stat_writes(z_stat_writes), .stat_errs(z_stat_errs)
`endif
    );

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One full transaction: accept, measure cycles until rsp_valid, check response, handshake.
    task automatic run_txn(input string tag, input logic s, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input int exp_lat, input logic [63:0] exp_rd,
                           input logic exp_er);
        int n;
        sel = s;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready_m && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 64'(req_ready_m), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
        n = 1;
        @(negedge clk);
        while (!rsp_valid_m && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " rdata"}, rsp_rdata_m, exp_rd);
        check({tag, " err"}, 64'(rsp_err_m), 64'(exp_er));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, " valid_clr"}, 64'(rsp_valid_m), 64'd0);
        check({tag, " rdata_clr"}, rsp_rdata_m, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b1, 64'h100, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[1]  = '{1'b1, 64'h108, 64'h1122334455667788, 64'h0, 1'b0};
        vecs[2]  = '{1'b0, 64'h100, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        vecs[3]  = '{1'b0, 64'h101, 64'h0, 64'h880123456789ABCD, 1'b0};
        vecs[4]  = '{1'b0, 64'h104, 64'h0, 64'h5566778801234567, 1'b0};
        vecs[5]  = '{1'b1, 64'h3F8, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0};
        vecs[6]  = '{1'b0, 64'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[7]  = '{1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1};
        vecs[8]  = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b1};
        vecs[9]  = '{1'b0, 64'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 64'h3F9, 64'h5555555555555555, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 64'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[12] = '{1'b1, 64'h203, 64'h0807060504030201, 64'h0, 1'b0};
        vecs[13] = '{1'b0, 64'h203, 64'h0, 64'h0807060504030201, 1'b0};
        vecs[14] = '{1'b0, 64'h10000000000003F8, 64'h0, 64'h0, 1'b1};

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset req_ready", 64'(a_req_ready), 64'd0);
        check("reset rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("reset rsp_rdata", a_rsp_rdata, 64'd0);
        check("reset rsp_err", 64'(a_rsp_err), 64'd0);
        check("reset req_ready lat0", 64'(z_req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("release req_ready before edge", 64'(a_req_ready), 64'd0);
        @(negedge clk);
        check("release req_ready after edge", 64'(a_req_ready), 64'd1);

        for (int i = 0; i < 15; i++) begin
            run_txn($sformatf("vec%0d", i), 1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    3, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: response held for 5 cycles while a second request waits.
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_write = 1'b1; req_addr = 64'h300; req_wdata = 64'h7777777777777777;
        n = 0;
        @(negedge clk);
        while (!a_rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d rsp_valid", k), 64'(a_rsp_valid), 64'd1);
            check($sformatf("bp%0d rsp_rdata", k), a_rsp_rdata, 64'h0123456789ABCDEF);
            check($sformatf("bp%0d req_ready", k), 64'(a_req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp handshake rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("bp handshake rsp_rdata", a_rsp_rdata, 64'd0);
        check("bp handshake req_ready", 64'(a_req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp second accepted", 64'(a_req_ready), 64'd0);
        n = 0;
        @(negedge clk);
        while (!a_rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("bp second rsp_valid", 64'(a_rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        run_txn("bp readback", 1'b0, 1'b0, 64'h300, 64'h0, 3, 64'h7777777777777777, 1'b0);

        // Reset during WAIT drops the in-flight write.
        run_txn("rst old write", 1'b0, 1'b1, 64'h180, 64'h1111111111111111, 3, 64'h0, 1'b0);
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h180; req_wdata = 64'h2222222222222222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwait rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("midwait req_ready", 64'(a_req_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("midwait held rsp_valid", 64'(a_rsp_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midwait release req_ready", 64'(a_req_ready), 64'd1);
        check("midwait release rsp_valid", 64'(a_rsp_valid), 64'd0);
        run_txn("midwait readback", 1'b0, 1'b0, 64'h180, 64'h0, 3, 64'h1111111111111111, 1'b0);

        // Zero-latency instance: 2 writes, 3 reads of which one is out of range.
        run_txn("z w0", 1'b1, 1'b1, 64'h10, 64'hA1A2A3A4A5A6A7A8, 1, 64'h0, 1'b0);
        run_txn("z w1", 1'b1, 1'b1, 64'h18, 64'hB1B2B3B4B5B6B7B8, 1, 64'h0, 1'b0);
        run_txn("z r0", 1'b1, 1'b0, 64'h10, 64'h0, 1, 64'hA1A2A3A4A5A6A7A8, 1'b0);
        run_txn("z r1", 1'b1, 1'b0, 64'h14, 64'h0, 1, 64'hB5B6B7B8A1A2A3A4, 1'b0);
        run_txn("z rerr", 1'b1, 1'b0, 64'h3FF, 64'h0, 1, 64'h0, 1'b1);
`ifdef DMEM_STATS_EN
        check("stat_reads", 64'(z_stat_reads), 64'd3);
        check("stat_writes", 64'(z_stat_writes), 64'd2);
        check("stat_errs", 64'(z_stat_errs), 64'd1);
        check("stat_reads lat2", 64'(a_stat_reads), 64'd1);
        check("stat_writes lat2", 64'(a_stat_writes), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
